// File: rtl/gemm_pkg.sv
// Shared types and constants for the tiled GEMM sequencer.
// Holds the FSM state enum, loader select codes and default tile edge.
package gemm_pkg;

    localparam int GEMM_BLOCK_DIM = 8;

    localparam logic LD_SEL_A = 1'b0;
    localparam logic LD_SEL_B = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_A,
        S_WT_A,
        S_LD_B,
        S_WT_B,
        S_CMP,
        S_WT_CMP,
        S_ST,
        S_WT_ST,
        S_DONE
    } state_t;

endpackage

// File: rtl/gemm_tile_addr_gen.sv
// Combinational A/B/C tile base-address and row-stride generator.
// Ports: k_dim/n_dim (latched element dims), mi/ni/ki (tile indices)
// in; a/b/c base addresses and strides out. Arithmetic wraps mod 2^AW.
module gemm_tile_addr_gen #(
    parameter int BLOCK_DIM  = 8,
    parameter int TILE_CNT_W = 6,
    parameter int ADDR_WIDTH = 20
) (
    input  logic [ADDR_WIDTH-1:0] k_dim,
    input  logic [ADDR_WIDTH-1:0] n_dim,
    input  logic [TILE_CNT_W-1:0] mi,
    input  logic [TILE_CNT_W-1:0] ni,
    input  logic [TILE_CNT_W-1:0] ki,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] a_stride,
    output logic [ADDR_WIDTH-1:0] b_addr,
    output logic [ADDR_WIDTH-1:0] b_stride,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [ADDR_WIDTH-1:0] c_stride
);

    localparam logic [ADDR_WIDTH-1:0] BD = ADDR_WIDTH'(BLOCK_DIM);

    logic [ADDR_WIDTH-1:0] mi_w;
    logic [ADDR_WIDTH-1:0] ni_w;
    logic [ADDR_WIDTH-1:0] ki_w;

    assign mi_w = ADDR_WIDTH'(mi);
    assign ni_w = ADDR_WIDTH'(ni);
    assign ki_w = ADDR_WIDTH'(ki);

    assign a_addr   = mi_w * BD * k_dim + ki_w * BD;
    assign a_stride = k_dim;
    assign b_addr   = ki_w * BD * n_dim + ni_w * BD;
    assign b_stride = n_dim;
    assign c_addr   = mi_w * BD * n_dim + ni_w * BD;
    assign c_stride = n_dim;

endmodule

// File: rtl/tiled_gemm_sequencer.sv
// Runtime-sized tile-loop controller: loads A/B tiles, runs the systolic
// multiply over k, stores each C tile. Ports: start/cfg_* job setup;
// busy/done/err_cfg status; ld_*, cmp_*, st_* unit handshakes.
// Optional GEMM_PERF_CNT_EN adds perf_busy_cycles/perf_stall_cycles.
module tiled_gemm_sequencer
    import gemm_pkg::*;
#(
    parameter int BLOCK_DIM  = GEMM_BLOCK_DIM,
    parameter int TILE_CNT_W = 6,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TILE_CNT_W-1:0] cfg_m_tiles,
    input  logic [TILE_CNT_W-1:0] cfg_n_tiles,
    input  logic [TILE_CNT_W-1:0] cfg_k_tiles,
    input  logic                  cfg_accumulate,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg,
    output logic                  ld_req_valid,
    input  logic                  ld_req_ready,
    output logic                  ld_req_sel,
    output logic [ADDR_WIDTH-1:0] ld_req_addr,
    output logic [ADDR_WIDTH-1:0] ld_req_stride,
    input  logic                  ld_done,
    output logic                  cmp_start,
    output logic                  cmp_clear,
    input  logic                  cmp_done,
    output logic                  st_req_valid,
    input  logic                  st_req_ready,
    output logic [ADDR_WIDTH-1:0] st_req_addr,
    output logic [ADDR_WIDTH-1:0] st_req_stride,
    output logic                  st_req_acc,
    input  logic                  st_done
`ifdef GEMM_PERF_CNT_EN
    ,
    output logic [31:0]           perf_busy_cycles,
    output logic [31:0]           perf_stall_cycles
`endif
);

    localparam logic [ADDR_WIDTH-1:0] BD_W = ADDR_WIDTH'(BLOCK_DIM);
    localparam logic [TILE_CNT_W-1:0] ONE  = TILE_CNT_W'(1);

    state_t state;
    state_t state_nxt;

    logic [TILE_CNT_W-1:0] m_q;
    logic [TILE_CNT_W-1:0] n_q;
    logic [TILE_CNT_W-1:0] k_q;
    logic [TILE_CNT_W-1:0] mi;
    logic [TILE_CNT_W-1:0] ni;
    logic [TILE_CNT_W-1:0] ki;
    logic [ADDR_WIDTH-1:0] k_dim;
    logic [ADDR_WIDTH-1:0] n_dim;
    logic                  acc_q;

    logic cfg_zero;
    logic job_go;
    logic k_last;
    logic n_last;
    logic m_last;

    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] a_stride;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [ADDR_WIDTH-1:0] b_stride;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [ADDR_WIDTH-1:0] c_stride;

    assign cfg_zero = (cfg_m_tiles == '0) || (cfg_n_tiles == '0) ||
                      (cfg_k_tiles == '0);
    assign job_go   = (state == S_IDLE) && start;
    assign k_last   = (ki == k_q - ONE);
    assign n_last   = (ni == n_q - ONE);
    assign m_last   = (mi == m_q - ONE);

    gemm_tile_addr_gen #(
        .BLOCK_DIM  (BLOCK_DIM),
        .TILE_CNT_W (TILE_CNT_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .k_dim    (k_dim),
        .n_dim    (n_dim),
        .mi       (mi),
        .ni       (ni),
        .ki       (ki),
        .a_addr   (a_addr),
        .a_stride (a_stride),
        .b_addr   (b_addr),
        .b_stride (b_stride),
        .c_addr   (c_addr),
        .c_stride (c_stride)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = cfg_zero ? S_DONE : S_LD_A;
            S_LD_A:   if (ld_req_ready) state_nxt = S_WT_A;
            S_WT_A:   if (ld_done) state_nxt = S_LD_B;
            S_LD_B:   if (ld_req_ready) state_nxt = S_WT_B;
            S_WT_B:   if (ld_done) state_nxt = S_CMP;
            S_CMP:    state_nxt = S_WT_CMP;
            S_WT_CMP: if (cmp_done) state_nxt = k_last ? S_ST : S_LD_A;
            S_ST:     if (st_req_ready) state_nxt = S_WT_ST;
            S_WT_ST: begin
                if (st_done) begin
                    state_nxt = (m_last && n_last) ? S_DONE : S_LD_A;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Job config and loop indices; cfg is frozen for the whole job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            k_dim   <= '0;
            n_dim   <= '0;
            acc_q   <= 1'b0;
            err_cfg <= 1'b0;
            mi      <= '0;
            ni      <= '0;
            ki      <= '0;
        end else if (job_go) begin
            m_q     <= cfg_m_tiles;
            n_q     <= cfg_n_tiles;
            k_q     <= cfg_k_tiles;
            k_dim   <= ADDR_WIDTH'(cfg_k_tiles) * BD_W;
            n_dim   <= ADDR_WIDTH'(cfg_n_tiles) * BD_W;
            acc_q   <= cfg_accumulate;
            err_cfg <= cfg_zero;
            mi      <= '0;
            ni      <= '0;
            ki      <= '0;
        end else if (state == S_WT_CMP && cmp_done && !k_last) begin
            ki <= ki + ONE;
        end else if (state == S_WT_ST && st_done) begin
            ki <= '0;
            if (n_last) begin
                ni <= '0;
                mi <= m_last ? '0 : mi + ONE;
            end else begin
                ni <= ni + ONE;
            end
        end
    end

    // Request fields are gated by their valid so idle outputs read zero.
    always_comb begin
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        ld_req_valid  = 1'b0;
        ld_req_sel    = LD_SEL_A;
        ld_req_addr   = '0;
        ld_req_stride = '0;
        cmp_start     = 1'b0;
        cmp_clear     = 1'b0;
        st_req_valid  = 1'b0;
        st_req_addr   = '0;
        st_req_stride = '0;
        st_req_acc    = 1'b0;
        unique case (state)
            S_LD_A: begin
                ld_req_valid  = 1'b1;
                ld_req_addr   = a_addr;
                ld_req_stride = a_stride;
            end
            S_LD_B: begin
                ld_req_valid  = 1'b1;
                ld_req_sel    = LD_SEL_B;
                ld_req_addr   = b_addr;
                ld_req_stride = b_stride;
            end
            S_CMP: begin
                cmp_start = 1'b1;
                cmp_clear = (ki == '0);
            end
            S_ST: begin
                st_req_valid  = 1'b1;
                st_req_addr   = c_addr;
                st_req_stride = c_stride;
                st_req_acc    = acc_q;
            end
            default: ;
        endcase
    end

`ifdef GEMM_PERF_CNT_EN
    logic stall;

    assign stall = (ld_req_valid && !ld_req_ready) ||
                   (st_req_valid && !st_req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (job_go) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && !(&perf_busy_cycles)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (stall && !(&perf_stall_cycles)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tiled_gemm_sequencer.sv
// Self-checking bench for tiled_gemm_sequencer: scoreboarded requests,
// directed job sequence; perf checks when GEMM_PERF_CNT_EN is defined.
module tb_tiled_gemm_sequencer;

    localparam int BD = 8;
    localparam int TW = 6;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [TW-1:0] cfg_m_tiles = '0;
    logic [TW-1:0] cfg_n_tiles = '0;
    logic [TW-1:0] cfg_k_tiles = '0;
    logic          cfg_accumulate = 1'b0;
    logic          busy, done, err_cfg;
    logic          ld_req_valid, ld_req_sel;
    logic          ld_req_ready = 1'b1;
    logic [AW-1:0] ld_req_addr, ld_req_stride;
    logic          ld_done = 1'b0;
    logic          cmp_start, cmp_clear;
    logic          cmp_done = 1'b0;
    logic          st_req_valid, st_req_acc;
    logic          st_req_ready = 1'b1;
    logic [AW-1:0] st_req_addr, st_req_stride;
    logic          st_done = 1'b0;
`ifdef GEMM_PERF_CNT_EN
    logic [31:0]   perf_busy_cycles, perf_stall_cycles;
`endif

    tiled_gemm_sequencer #(
        .BLOCK_DIM (BD), .TILE_CNT_W (TW), .ADDR_WIDTH (AW)
    ) dut (
        .clk (clk), .rst (rst), .start (start),
        .cfg_m_tiles (cfg_m_tiles), .cfg_n_tiles (cfg_n_tiles),
        .cfg_k_tiles (cfg_k_tiles), .cfg_accumulate (cfg_accumulate),
        .busy (busy), .done (done), .err_cfg (err_cfg),
        .ld_req_valid (ld_req_valid), .ld_req_ready (ld_req_ready),
        .ld_req_sel (ld_req_sel), .ld_req_addr (ld_req_addr),
        .ld_req_stride (ld_req_stride), .ld_done (ld_done),
        .cmp_start (cmp_start), .cmp_clear (cmp_clear),
        .cmp_done (cmp_done),
        .st_req_valid (st_req_valid), .st_req_ready (st_req_ready),
        .st_req_addr (st_req_addr), .st_req_stride (st_req_stride),
        .st_req_acc (st_req_acc), .st_done (st_done)
`ifdef GEMM_PERF_CNT_EN
        , .perf_busy_cycles (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: {sel/acc, addr, stride}
    logic [40:0] ld_q[$];
    logic [40:0] st_q[$];
    logic        cmp_q[$];
    logic [40:0] a_log[$];
    logic [40:0] b_log[$];
    logic [40:0] c_log[$];

    // controls written by the main sequence only
    logic ld_rdy_en = 1'b1;
    logic ld_hold = 1'b0;
    logic cmp_hold = 1'b0;
    int   inj_req = 0;

    // responder/monitor state
    int   inj_seen = 0;
    logic ld_pend = 1'b0, cmp_pend = 1'b0, st_pend = 1'b0;
    int   ld_hs = 0, st_hs = 0, cmp_cnt = 0, clr_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            ld_pend = 1'b0; cmp_pend = 1'b0; st_pend = 1'b0;
            ld_done = 1'b0; cmp_done = 1'b0; st_done = 1'b0;
            ld_q.delete(); st_q.delete(); cmp_q.delete();
            inj_seen = inj_req;
        end else begin
            ld_done = ld_pend && !ld_hold;
            if (ld_done) ld_pend = 1'b0;
            cmp_done = cmp_pend && !cmp_hold;
            if (cmp_done) cmp_pend = 1'b0;
            if (inj_req != inj_seen) begin
                cmp_done = 1'b1;
                inj_seen = inj_req;
            end
            st_done = st_pend;
            st_pend = 1'b0;
            ld_req_ready = ld_rdy_en;
            st_req_ready = 1'b1;
            if (ld_req_valid && ld_req_ready) begin
                ld_hs++;
                ld_pend = 1'b1;
                if (ld_req_sel) b_log.push_back({ld_req_sel, ld_req_addr, ld_req_stride});
                else a_log.push_back({ld_req_sel, ld_req_addr, ld_req_stride});
                check("ld_q_nonempty", 64'(ld_q.size() > 0), 64'd1);
                if (ld_q.size() > 0)
                    check("ld_req", 64'({ld_req_sel, ld_req_addr, ld_req_stride}),
                          64'(ld_q.pop_front()));
            end
            if (cmp_start) begin
                cmp_cnt++;
                if (cmp_clear) clr_cnt++;
                cmp_pend = 1'b1;
                check("cmp_q_nonempty", 64'(cmp_q.size() > 0), 64'd1);
                if (cmp_q.size() > 0)
                    check("cmp_clear", 64'(cmp_clear), 64'(cmp_q.pop_front()));
            end
            if (st_req_valid && st_req_ready) begin
                st_hs++;
                st_pend = 1'b1;
                c_log.push_back({st_req_acc, st_req_addr, st_req_stride});
                check("st_q_nonempty", 64'(st_q.size() > 0), 64'd1);
                if (st_q.size() > 0)
                    check("st_req", 64'({st_req_acc, st_req_addr, st_req_stride}),
                          64'(st_q.pop_front()));
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input int m, input int n, input int k,
                            input logic acc);
        logic [AW-1:0] a, b, c, kd, nd;
        if (m == 0 || n == 0 || k == 0) return;
        kd = AW'(k * BD);
        nd = AW'(n * BD);
        for (int mi = 0; mi < m; mi++)
            for (int ni = 0; ni < n; ni++) begin
                for (int ki = 0; ki < k; ki++) begin
                    a = AW'(mi * BD * k * BD + ki * BD);
                    b = AW'(ki * BD * n * BD + ni * BD);
                    ld_q.push_back({1'b0, a, kd});
                    ld_q.push_back({1'b1, b, nd});
                    cmp_q.push_back(ki == 0);
                end
                c = AW'(mi * BD * n * BD + ni * BD);
                st_q.push_back({acc, c, nd});
            end
    endtask

    // Ends one cycle after the start edge (first busy cycle).
    task automatic start_job(input int m, input int n, input int k,
                             input logic acc);
        push_job(m, n, k, acc);
        cfg_m_tiles = TW'(m);
        cfg_n_tiles = TW'(n);
        cfg_k_tiles = TW'(k);
        cfg_accumulate = acc;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_m_tiles = '0;
        cfg_n_tiles = '0;
        cfg_k_tiles = '0;
    endtask

    // Steps until done, counting busy cycles seen; then one more step.
    task automatic wait_done(input int maxc, output int nbusy);
        bit got = 0;
        nbusy = 0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (busy) nbusy++;
            if (done) begin
                got = 1;
                break;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        step();
        check("idle_after_done", 64'({busy, done}), 64'd0);
    endtask

    task automatic check_drained();
        check("ld_q_empty", 64'(ld_q.size()), 64'd0);
        check("st_q_empty", 64'(st_q.size()), 64'd0);
        check("cmp_q_empty", 64'(cmp_q.size()), 64'd0);
    endtask

    initial begin
        int ld0, st0, cmp0, clr0, dn0, a0, c0, nb;
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ld0, st0, cmp0, clr0, dn0, a0, b0, c0, nb;
        rst = 1'b1;
        step();
        step();
        // reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_cfg), 64'd0);
        check("rst_ld_valid", 64'(ld_req_valid), 64'd0);
        check("rst_ld_addr", 64'(ld_req_addr), 64'd0);
        check("rst_ld_stride", 64'(ld_req_stride), 64'd0);
        check("rst_cmp", 64'({cmp_start, cmp_clear}), 64'd0);
        check("rst_st", 64'({st_req_valid, st_req_acc, st_req_addr}), 64'd0);
        rst = 1'b0;
        step();

        // basic 2x2x2
        ld0 = ld_hs; st0 = st_hs; cmp0 = cmp_cnt; clr0 = clr_cnt;
        dn0 = done_cnt; a0 = a_log.size(); b0 = b_log.size();
        c0 = c_log.size();
        start_job(2, 2, 2, 1'b0);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done(400, nb);
        check("t1_busy_len", 64'(nb + 1), 64'd57);
        check("t1_a_loads", 64'(a_log.size() - a0), 64'd8);
        check("t1_b_loads", 64'(b_log.size() - b0), 64'd8);
        check("t1_loads", 64'(ld_hs - ld0), 64'd16);
        check("t1_cmps", 64'(cmp_cnt - cmp0), 64'd8);
        check("t1_clears", 64'(clr_cnt - clr0), 64'd4);
        check("t1_stores", 64'(st_hs - st0), 64'd4);
        check("t1_done_cnt", 64'(done_cnt - dn0), 64'd1);
        if (a_log.size() >= a0 + 6 && c_log.size() >= c0 + 3) begin
            check("t1_a_addr_110", 64'(a_log[a0 + 5][39:20]), 64'd136);
            check("t1_a_strd_110", 64'(a_log[a0 + 5][19:0]), 64'd16);
            check("t1_b_addr_110", 64'(b_log[b0 + 5][39:20]), 64'd128);
            check("t1_c_addr_10", 64'(c_log[c0 + 2][39:20]), 64'd128);
            check("t1_c_acc_10", 64'(c_log[c0 + 2][40]), 64'd0);
        end
        check_drained();

        // zero tile count
        ld0 = ld_hs; st0 = st_hs; cmp0 = cmp_cnt; dn0 = done_cnt;
        start_job(0, 2, 2, 1'b0);
        check("t2_done_pulse", 64'(done), 64'd1);
        check("t2_err", 64'(err_cfg), 64'd1);
        check("t2_ld_valid", 64'(ld_req_valid), 64'd0);
        step();
        check("t2_done_low", 64'({busy, done}), 64'd0);
        check("t2_err_hold", 64'(err_cfg), 64'd1);
        check("t2_no_act", 64'((ld_hs - ld0) + (st_hs - st0) + (cmp_cnt - cmp0)), 64'd0);
        check("t2_done_cnt", 64'(done_cnt - dn0), 64'd1);
        start_job(1, 1, 1, 1'b0);
        check("t2_err_clr", 64'(err_cfg), 64'd0);
        wait_done(100, nb);
        check_drained();

        // backpressure on the loader
        ld_rdy_en = 1'b0;
        ld0 = ld_hs;
        start_job(1, 1, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", 64'({ld_req_valid, ld_req_sel, ld_req_addr, ld_req_stride}),
                  64'({1'b1, 1'b0, 20'd0, 20'd8}));
            step();
        end
        check("t3_no_accept", 64'(ld_hs - ld0), 64'd0);
        ld_rdy_en = 1'b1;
        step();
        check("t3_one_accept", 64'(ld_hs - ld0), 64'd1);
        check("t3_valid_drop", 64'(ld_req_valid), 64'd0);
        wait_done(100, nb);
        check_drained();

        // accumulate + spurious cmp_done during WT_A
        ld_hold = 1'b1;
        ld0 = ld_hs; st0 = st_hs; cmp0 = cmp_cnt; c0 = c_log.size();
        start_job(1, 1, 1, 1'b1);
        for (int i = 0; i < 20 && ld_hs == ld0; i++) step();
        check("t4_in_wt_a", 64'({busy, ld_req_valid}), 64'b10);
        inj_req++;
        step();
        step();
        check("t4_still_wt_a", 64'({busy, ld_req_valid, st_req_valid, cmp_start}), 64'b1000);
        check("t4_no_cmp", 64'(cmp_cnt - cmp0), 64'd0);
        ld_hold = 1'b0;
        wait_done(100, nb);
        check("t4_stores", 64'(st_hs - st0), 64'd1);
        if (c_log.size() > c0)
            check("t4_st_acc", 64'(c_log[c0][40]), 64'd1);
        check_drained();

        // reset in WT_CMP
        cmp_hold = 1'b1;
        cmp0 = cmp_cnt; dn0 = done_cnt;
        start_job(3, 1, 3, 1'b0);
        for (int i = 0; i < 30 && cmp_cnt == cmp0; i++) step();
        step();
        check("t5_wt_cmp", 64'({busy, cmp_start, ld_req_valid}), 64'b100);
        rst = 1'b1;
        #1;
        check("t5_rst_outs", 64'({busy, done, err_cfg, ld_req_valid, cmp_start,
                                  cmp_clear, st_req_valid, st_req_acc}), 64'd0);
        check("t5_rst_addr", 64'({ld_req_addr, st_req_addr}), 64'd0);
        step();
        rst = 1'b0;
        cmp_hold = 1'b0;
        step();
        step();
        check("t5_no_done", 64'(done_cnt - dn0), 64'd0);
        check("t5_idle", 64'(busy), 64'd0);
        st0 = st_hs;
        start_job(1, 2, 1, 1'b0);
        wait_done(100, nb);
        check("t5_fresh_st", 64'(st_hs - st0), 64'd2);
        check("t5_fresh_done", 64'(done_cnt - dn0), 64'd1);
        check_drained();

`ifdef GEMM_PERF_CNT_EN
        ld_rdy_en = 1'b0;
        start_job(1, 1, 1, 1'b0);
        nb = busy ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy) nb++;
        end
        ld_rdy_en = 1'b1;
        begin
            int nb2;
            wait_done(100, nb2);
            nb += nb2;
        end
        check("t6_stall", 64'(perf_stall_cycles), 64'd3);
        check("t6_busy", 64'(perf_busy_cycles), 64'(nb));
        check("t6_busy_len", 64'(nb), 64'd12);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
